multicycle_ctrl: RTL and testbench

Multi-cycle control unit that sequences the 9-bit ISA and produces the 3-bit ALU command, register-file addresses/write strobes, and instruction/data memory handshakes. It sits upstream of the combinational ALU: it drives `alu_cmd` and operand register selects, then captures the ALU result for write-back, branch resolution or memory addressing. It owns the PC, the instruction register and the run/halt state.

---
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 9-bit ISA: owns PC, IR and run/halt state,
// drives the ALU command and register selects, and handshakes with data memory.
module multicycle_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_rdata,
  output logic [2:0]       alu_cmd,
  input  logic [7:0]       alu_rslt,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  input  logic [7:0]       rf_rdata_a,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [7:0]       rf_wdata,
  output logic [7:0]       dmem_addr,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic [7:0]       dmem_wdata,
  input  logic [7:0]       dmem_rdata,
  input  logic             dmem_ack,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [8:0] HALT_IR = 9'h1FF;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [8:0]       r_ir;
  logic [7:0]       r_rslt_q;
  logic [CNT_W-1:0] r_retired;
  logic             r_done;
  logic [2:0]       r_alu_cmd;
  logic [2:0]       r_rf_raddr_a;
  logic [2:0]       r_rf_raddr_b;
  logic             r_rf_we;
  logic             r_dmem_re;
  logic             r_dmem_we;

  logic [2:0]       w_op;
  logic [2:0]       w_ra;
  logic [2:0]       w_rb;
  logic [2:0]       w_dec_op;
  logic [2:0]       w_dec_ra;
  logic [2:0]       w_dec_rb;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_br;
  logic [CNT_W-1:0] w_retired_next;

  assign w_op     = r_ir[8:6];
  assign w_ra     = r_ir[5:3];
  assign w_rb     = r_ir[2:0];
  assign w_dec_op = imem_rdata[8:6];
  assign w_dec_ra = imem_rdata[5:3];
  assign w_dec_rb = imem_rdata[2:0];

  // PC arithmetic wraps naturally at PC_W bits; rb is a signed -4..+3 offset.
  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_pc_br  = r_pc + {{(PC_W-3){w_rb[2]}}, w_rb};
  assign w_retired_next = (r_retired == {CNT_W{1'b1}}) ? r_retired
                        : r_retired + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_rslt_q     <= '0;
      r_retired    <= '0;
      r_done       <= 1'b0;
      r_alu_cmd    <= 3'd0;
      r_rf_raddr_a <= 3'd0;
      r_rf_raddr_b <= 3'd0;
      r_rf_we      <= 1'b0;
      r_dmem_re    <= 1'b0;
      r_dmem_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_retired <= '0;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= imem_rdata;
          if (imem_rdata == HALT_IR) begin
            r_state <= S_HALT;
            r_done  <= 1'b1;
          end else begin
            // EXEC-cycle outputs are loaded here so they are registered on entry.
            r_state      <= S_EXEC;
            r_alu_cmd    <= w_dec_op;
            r_rf_raddr_a <= (w_dec_op == OP_BNE) ? 3'd0 : w_dec_rb;
            r_rf_raddr_b <= (w_dec_op[2:1] == 2'b11) ? 3'd0 : w_dec_ra;
          end
        end
        S_EXEC: begin
          r_rslt_q     <= alu_rslt;
          r_alu_cmd    <= 3'd0;
          r_rf_raddr_a <= 3'd0;
          r_rf_raddr_b <= 3'd0;
          if (w_op == OP_BNE) begin
            r_state   <= S_FETCH;
            r_pc      <= (alu_rslt == 8'd1) ? w_pc_br : w_pc_inc;
            r_retired <= w_retired_next;
          end else if (w_op[2:1] == 2'b11) begin
            r_state      <= S_MEM;
            r_dmem_re    <= ~w_op[0];
            r_dmem_we    <= w_op[0];
            r_rf_raddr_a <= w_ra;
          end else begin
            r_state <= S_WB;
            r_rf_we <= 1'b1;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_re    <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_rf_raddr_a <= 3'd0;
            if (r_dmem_re) begin
              r_rslt_q <= dmem_rdata;
              r_state  <= S_WB;
              r_rf_we  <= 1'b1;
            end else begin
              r_state   <= S_FETCH;
              r_pc      <= w_pc_inc;
              r_retired <= w_retired_next;
            end
          end
        end
        S_WB: begin
          r_rf_we   <= 1'b0;
          r_state   <= S_FETCH;
          r_pc      <= w_pc_inc;
          r_retired <= w_retired_next;
        end
        S_HALT: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_retired <= '0;
            r_done    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done       = r_done;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign retired    = r_retired;
  assign alu_cmd    = r_alu_cmd;
  assign rf_raddr_a = r_rf_raddr_a;
  assign rf_raddr_b = r_rf_raddr_b;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_we ? w_ra : 3'd0;
  assign rf_wdata   = r_rf_we ? r_rslt_q : 8'd0;
  assign dmem_re    = r_dmem_re;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = (r_dmem_re | r_dmem_we) ? r_rslt_q : 8'd0;
  // Store data comes straight from port A, which selects ra throughout MEM.
  assign dmem_wdata = r_dmem_we ? rf_rdata_a : 8'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with instruction memory, register file and ALU models.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_rdata = 9'h000;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_rslt;
  logic [2:0]  rf_raddr_a, rf_raddr_b;
  logic [7:0]  rf_rdata_a;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  dmem_addr;
  logic        dmem_re, dmem_we;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata = 8'h00;
  logic        dmem_ack = 1'b0;
  logic [7:0]  pc;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] imem [256];
  logic [7:0] rf [8];
  int         wr_count = 0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] alu_a, alu_b;

  localparam logic [8:0] I_ADD12  = 9'b001_001_010;
  localparam logic [8:0] I_AND55  = 9'b000_101_101;
  localparam logic [8:0] I_BNE3M4 = 9'b011_011_100;
  localparam logic [8:0] I_LW64   = 9'b110_110_100;
  localparam logic [8:0] I_SW14   = 9'b111_001_100;
  localparam logic [8:0] I_HALT   = 9'h1FF;

  multicycle_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_cmd(alu_cmd), .alu_rslt(alu_rslt),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem[imem_addr];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] = rf_wdata;
    if (dmem_we && dmem_ack) begin
      wr_count = wr_count + 1;
      wr_addr  = dmem_addr;
      wr_data  = dmem_wdata;
    end
  end

  assign alu_a      = rf[rf_raddr_a];
  assign alu_b      = rf[rf_raddr_b];
  assign rf_rdata_a = rf[rf_raddr_a];

  always_comb begin
    alu_rslt = 8'h00;
    case (alu_cmd)
      3'b000:  alu_rslt = alu_a & alu_b;
      3'b001:  alu_rslt = alu_a + alu_b;
      3'b010:  alu_rslt = alu_a ^ alu_b;
      3'b011:  alu_rslt = (alu_a != alu_b) ? 8'd1 : 8'd0;
      3'b100:  alu_rslt = alu_a << alu_b[2:0];
      3'b101:  alu_rslt = alu_a >> alu_b[2:0];
      default: alu_rslt = alu_a + alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem[i] = I_HALT;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL rst_pc: got %0d exp 0", pc); end
    vectors++; if (retired !== 16'd0) begin miscompares++; $display("FAIL rst_retired: got %0d exp 0", retired); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b exp 0", done); end
    vectors++; if (alu_cmd !== 3'd0) begin miscompares++; $display("FAIL rst_alu_cmd: got %0d exp 0", alu_cmd); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rst_rf_we: got %b exp 0", rf_we); end
    vectors++; if ({dmem_re, dmem_we} !== 2'b00) begin miscompares++; $display("FAIL rst_dmem_strobes: got %b exp 00", {dmem_re, dmem_we}); end
    vectors++; if (imem_addr !== 8'd0) begin miscompares++; $display("FAIL rst_imem_addr: got %0d exp 0", imem_addr); end
    vectors++; if (dmem_addr !== 8'd0) begin miscompares++; $display("FAIL rst_dmem_addr: got %0d exp 0", dmem_addr); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    vectors++; if ({done, pc} !== 9'd0) begin miscompares++; $display("FAIL idle_hold: got done=%b pc=%0d exp 0/0", done, pc); end
    $display("test_reset: reset and idle state checked");
  endtask

  task automatic test_add_halt();
    fill_imem();
    imem[0] = I_ADD12; imem[1] = I_HALT;
    rf[1] = 8'd5; rf[2] = 8'd7;
    pulse_start();
    vectors++; if (imem_addr !== 8'd0) begin miscompares++; $display("FAIL add_fetch_addr: got %0d exp 0", imem_addr); end
    tick(); tick();
    vectors++; if (alu_cmd !== 3'b001) begin miscompares++; $display("FAIL add_alu_cmd: got %b exp 001", alu_cmd); end
    vectors++; if ({rf_raddr_a, rf_raddr_b} !== {3'd2, 3'd1}) begin miscompares++; $display("FAIL add_raddr: got a=%0d b=%0d exp a=2 b=1", rf_raddr_a, rf_raddr_b); end
    tick();
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL add_wb_we: got %b exp 1", rf_we); end
    vectors++; if (rf_waddr !== 3'd1) begin miscompares++; $display("FAIL add_wb_waddr: got %0d exp 1", rf_waddr); end
    vectors++; if (rf_wdata !== 8'd12) begin miscompares++; $display("FAIL add_wb_wdata: got %0d exp 12", rf_wdata); end
    vectors++; if (alu_cmd !== 3'd0) begin miscompares++; $display("FAIL add_wb_alu_cmd: got %0d exp 0", alu_cmd); end
    tick();
    vectors++; if (pc !== 8'd1) begin miscompares++; $display("FAIL add_pc: got %0d exp 1", pc); end
    vectors++; if (retired !== 16'd1) begin miscompares++; $display("FAIL add_retired: got %0d exp 1", retired); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL add_we_drop: got %b exp 0", rf_we); end
    vectors++; if (rf[1] !== 8'd12) begin miscompares++; $display("FAIL add_r1: got %0d exp 12", rf[1]); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL halt_early_done: got %b exp 0", done); end
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL halt_done: got %b exp 1", done); end
    vectors++; if (retired !== 16'd1) begin miscompares++; $display("FAIL halt_retired: got %0d exp 1", retired); end
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL halt_done_hold: got %b exp 1", done); end
    $display("test_add_halt: ADD r1,r2 then HALT");
  endtask

  task automatic test_restart();
    pulse_start();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %b exp 0", done); end
    vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL restart_pc: got %0d exp 0", pc); end
    vectors++; if (retired !== 16'd0) begin miscompares++; $display("FAIL restart_retired: got %0d exp 0", retired); end
    do_reset();
    $display("test_restart: start in HALT restarts at pc 0");
  endtask

  task automatic test_start_ignored();
    fill_imem();
    imem[0] = I_ADD12;
    rf[1] = 8'd5; rf[2] = 8'd7;
    pulse_start();
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL exec_start_wb: got rf_we=%b exp 1", rf_we); end
    vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL exec_start_pc: got %0d exp 0", pc); end
    tick();
    vectors++; if ({pc, retired} !== {8'd1, 16'd1}) begin miscompares++; $display("FAIL exec_start_retire: got pc=%0d ret=%0d exp 1/1", pc, retired); end
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL exec_start_done: got %b exp 1", done); end
    do_reset();
    $display("test_start_ignored: start during EXEC ignored");
  endtask

  task automatic test_bne(input logic [7:0] r3_val, input logic [7:0] exp_pc);
    fill_imem();
    imem[0] = I_AND55; imem[1] = I_AND55; imem[2] = I_BNE3M4;
    rf[0] = 8'd0; rf[3] = r3_val; rf[5] = 8'h33;
    pulse_start();
    for (int i = 0; i < 8; i++) tick();
    vectors++; if (pc !== 8'd2) begin miscompares++; $display("FAIL bne_pre_pc: got %0d exp 2", pc); end
    tick(); tick();
    vectors++; if (alu_cmd !== 3'b011) begin miscompares++; $display("FAIL bne_alu_cmd: got %b exp 011", alu_cmd); end
    tick();
    vectors++; if (pc !== exp_pc) begin miscompares++; $display("FAIL bne_pc: got %0d exp %0d", pc, exp_pc); end
    vectors++; if (retired !== 16'd3) begin miscompares++; $display("FAIL bne_retired: got %0d exp 3", retired); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL bne_no_wb: got %b exp 0", rf_we); end
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bne_then_halt: got %b exp 1", done); end
    do_reset();
    $display("test_bne: R3=%0d -> pc %0d", r3_val, exp_pc);
  endtask

  task automatic test_lw();
    fill_imem();
    imem[0] = I_LW64;
    rf[0] = 8'd0; rf[4] = 8'h10; rf[6] = 8'h00;
    pulse_start();
    tick(); tick();
    vectors++; if (alu_cmd !== 3'b110) begin miscompares++; $display("FAIL lw_alu_cmd: got %b exp 110", alu_cmd); end
    vectors++; if ({rf_raddr_a, rf_raddr_b} !== {3'd4, 3'd0}) begin miscompares++; $display("FAIL lw_raddr: got a=%0d b=%0d exp a=4 b=0", rf_raddr_a, rf_raddr_b); end
    for (int w = 0; w < 3; w++) begin
      tick();
      vectors++; if ({dmem_re, dmem_we} !== 2'b10) begin miscompares++; $display("FAIL lw_mem_strobes_%0d: got %b exp 10", w, {dmem_re, dmem_we}); end
      vectors++; if (dmem_addr !== 8'h10) begin miscompares++; $display("FAIL lw_mem_addr_%0d: got %h exp 10", w, dmem_addr); end
    end
    dmem_ack = 1'b1; dmem_rdata = 8'hA5;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 8'h00;
    vectors++; if (dmem_re !== 1'b0) begin miscompares++; $display("FAIL lw_re_drop: got %b exp 0", dmem_re); end
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd6, 8'hA5}) begin miscompares++; $display("FAIL lw_wb: got we=%b wa=%0d wd=%h exp 1/6/a5", rf_we, rf_waddr, rf_wdata); end
    tick();
    vectors++; if (rf[6] !== 8'hA5) begin miscompares++; $display("FAIL lw_r6: got %h exp a5", rf[6]); end
    vectors++; if ({pc, retired} !== {8'd1, 16'd1}) begin miscompares++; $display("FAIL lw_retire: got pc=%0d ret=%0d exp 1/1", pc, retired); end
    do_reset();
    $display("test_lw: LW with 3-cycle ack");
  endtask

  task automatic test_sw_wrap();
    int wc0;
    fill_imem();
    imem[0] = I_AND55; imem[1] = I_AND55; imem[2] = I_BNE3M4;
    imem[254] = I_AND55; imem[255] = I_SW14;
    rf[0] = 8'd0; rf[1] = 8'h3C; rf[3] = 8'd9; rf[4] = 8'h20;
    wc0 = wr_count;
    pulse_start();
    for (int i = 0; i < 15; i++) tick();
    vectors++; if (pc !== 8'd255) begin miscompares++; $display("FAIL sw_pre_pc: got %0d exp 255", pc); end
    tick(); tick();
    vectors++; if (alu_cmd !== 3'b111) begin miscompares++; $display("FAIL sw_alu_cmd: got %b exp 111", alu_cmd); end
    tick();
    vectors++; if ({dmem_re, dmem_we} !== 2'b01) begin miscompares++; $display("FAIL sw_strobes: got %b exp 01", {dmem_re, dmem_we}); end
    vectors++; if (dmem_addr !== 8'h20) begin miscompares++; $display("FAIL sw_addr: got %h exp 20", dmem_addr); end
    vectors++; if (dmem_wdata !== 8'h3C) begin miscompares++; $display("FAIL sw_wdata: got %h exp 3c", dmem_wdata); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL sw_rf_we: got %b exp 0", rf_we); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL sw_we_drop: got %b exp 0", dmem_we); end
    vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL sw_pc_wrap: got %0d exp 0", pc); end
    vectors++; if (retired !== 16'd5) begin miscompares++; $display("FAIL sw_retired: got %0d exp 5", retired); end
    vectors++; if (wr_count !== wc0 + 1) begin miscompares++; $display("FAIL sw_write_count: got %0d exp %0d", wr_count, wc0 + 1); end
    vectors++; if ({wr_addr, wr_data} !== {8'h20, 8'h3C}) begin miscompares++; $display("FAIL sw_write_data: got %h/%h exp 20/3c", wr_addr, wr_data); end
    do_reset();
    $display("test_sw_wrap: SW at pc 255 wraps to 0");
  endtask

  task automatic test_reset_mid_mem();
    fill_imem();
    imem[0] = I_LW64;
    rf[0] = 8'd0; rf[4] = 8'h10; rf[6] = 8'h00;
    pulse_start();
    tick(); tick(); tick();
    vectors++; if (dmem_re !== 1'b1) begin miscompares++; $display("FAIL midmem_re: got %b exp 1", dmem_re); end
    rst_n = 1'b0;
    #1;
    vectors++; if (dmem_re !== 1'b0) begin miscompares++; $display("FAIL midmem_rst_re: got %b exp 0", dmem_re); end
    vectors++; if ({pc, retired} !== 24'd0) begin miscompares++; $display("FAIL midmem_rst_pc_ret: got pc=%0d ret=%0d exp 0/0", pc, retired); end
    tick();
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 8'h77;
    tick(); tick();
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL midmem_late_ack_we: got %b exp 0", rf_we); end
    vectors++; if (rf[6] !== 8'h00) begin miscompares++; $display("FAIL midmem_r6: got %h exp 00", rf[6]); end
    vectors++; if ({dmem_re, pc, done} !== 10'd0) begin miscompares++; $display("FAIL midmem_idle: got re=%b pc=%0d done=%b exp 0/0/0", dmem_re, pc, done); end
    dmem_ack = 1'b0; dmem_rdata = 8'h00;
    $display("test_reset_mid_mem: in-flight LW dropped by reset");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    fill_imem();
    test_reset();
    test_add_halt();
    test_restart();
    test_start_ignored();
    test_bne(8'd9, 8'd254);
    test_bne(8'd0, 8'd3);
    test_lw();
    test_sw_wrap();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
